fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the synchronous FIFO's single write port among `N_REQ` producers. Each producer uses a valid/ready handshake. Accepted beats are registered onto the FIFO write port. A granted producer may keep the port for a bounded burst. Admission is gated on FIFO full/almost-full so the FIFO never overflows, and any lost write is flagged through `wr_ack`/`overflow` supervision.

## Interface
- `N_REQ`, 4, number of producers (≥2).
- `MAX_BURST`, 4, max consecutive accepted beats per grant (≥1).
- `FIFO_WIDTH`, from `fifo_pack` (16), data width.
- `FIFO_DEPTH`, from `fifo_pack` (8), FIFO capacity.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-producer beat valid.
- `req_data`  in  N_REQ*FIFO_WIDTH  producer i data at slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- `req_ready`  out  N_REQ  one-hot or zero; combinational.
- `fifo_wr_en`  out  1  registered write strobe to FIFO.
- `fifo_data_in`  out  FIFO_WIDTH  registered write data.
- `fifo_full`, `fifo_almostfull`, `fifo_wr_ack`, `fifo_overflow`  in  1 each  FIFO status.
- `grant_id`  out  $clog2(N_REQ)  current owner (valid when `busy`).
- `busy`  out  1  state is GRANT.
- `drop_err`  out  1  sticky lost-write flag.

## Operation
- Transfer on producer i: `req_valid[i] && req_ready[i]`.
- `space_ok = !fifo_full && !(fifo_wr_en && fifo_almostfull)`. This accounts for the one beat in flight in the output register.
- `req_ready[i] = busy && grant_id==i && space_ok`. All other bits are 0.
- On a transfer, `fifo_data_in <= req_data[i]` and `fifo_wr_en <= 1`. Otherwise `fifo_wr_en <= 0` and `fifo_data_in` holds its value.
- State IDLE:
  - If any `req_valid` is high, latch `grant_id` = first valid index at or after `rr_ptr` (circular), clear `burst_cnt`, and go to GRANT.
- State GRANT:
  - Each transfer increments `burst_cnt`.
  - The grant ends when a transfer makes `burst_cnt==MAX_BURST`, or when `req_valid[grant_id]` is low.
  - On end: `rr_ptr <= grant_id+1` (mod N_REQ).
  - On end, if any `req_valid` is high this cycle, re-arbitrate immediately from `grant_id+1` and stay in GRANT with `burst_cnt` cleared. Otherwise go to IDLE.
  - A stall (`!space_ok`) holds the grant and `burst_cnt`. The grant never rotates on stall.
- Supervision:
  - `ack_exp <= fifo_wr_en`.
  - `drop_err <= 1` if `(ack_exp && !fifo_wr_ack) || fifo_overflow`.
  - Cleared only by `rst`.
- Reset values: `fifo_wr_en` 0, `fifo_data_in` 0, `req_ready` 0, `grant_id` 0, `busy` 0, `drop_err` 0. Internal: state IDLE, `rr_ptr` 0, `burst_cnt` 0, `ack_exp` 0.
- Reset mid-burst: any in-flight beat is discarded (no `fifo_wr_en` the cycle after `rst`). Producers see `req_ready` 0.

## Timing
- Cycle 0: valid seen in IDLE.
- Cycle 1: `busy`/`grant_id` valid; `req_ready` high if `space_ok`.
- Cycle 2: `fifo_wr_en` high.
- Cycle 3: `fifo_wr_ack` expected.
- In GRANT with space, throughput is 1 beat/cycle. The grant switch on burst end costs 0 cycles; the return from IDLE costs 1 cycle.
- `burst_cnt` width is $clog2(MAX_BURST+1). `rr_ptr` wraps from N_REQ-1 to 0.
- When `req_valid` drops on the same cycle the burst limit is hit, the result is a single exit with one `rr_ptr` update.

## Structure
- `fifo_pack` holds `FIFO_WIDTH` and `FIFO_DEPTH`, plus the new typedef `arb_state_e {ARB_IDLE, ARB_GRANT}`.
- Sub-module `rr_pick`: combinational circular priority picker. Inputs are the request vector and start index; outputs are found and index. It is used for both IDLE and end-of-grant arbitration.

## Test plan
- Hold `rst` 1 for 2 cycles with all `req_valid` high → every output is 0. After `rst` falls, grant goes to 0.
- Producer 0 only, beats 0x00A1, 0x00A2, 0x00A3 → `fifo_wr_en` high for 3 consecutive cycles starting cycle 2 with those data. `drop_err` stays 0.
- All four producers continuously valid, FIFO drained every cycle, `MAX_BURST`=4 → `grant_id` sequence is 0,1,2,3,0 with exactly 4 beats each and no idle gaps.
- Producer 2 streams with no FIFO reads → exactly 8 writes occur, then `req_ready` stays 0. `fifo_overflow` never asserts. One FIFO read then admits exactly one more beat.
- Bench holds `fifo_wr_ack` 0 on the cycle after a `fifo_wr_en` → `drop_err` rises the next cycle and stays 1 until `rst`.
- Assert `rst` on the 2nd beat of producer 1's burst → `fifo_wr_en` is 0 the next cycle and state is IDLE. The next grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_pack.sv
// Shared FIFO geometry and arbiter state encoding used by the write-port arbiter.
package fifo_pack;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Circular successor of a producer index in a ring of n entries.
    function automatic int rr_wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first asserted request at or after start.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0]   pos_s;
    logic [IW-1:0] cand_s;

    // Scan the ring starting at start; the earliest hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = start;
        pos_s  = {(IW+1){1'b0}};
        cand_s = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            pos_s = {1'b0, start} + (IW+1)'(k);
            if (pos_s >= (IW+1)'(N)) begin
                pos_s = pos_s - (IW+1)'(N);
            end else begin
                pos_s = pos_s;
            end
            cand_s = pos_s[IW-1:0];
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// with bounded bursts, full/almost-full admission and lost-write supervision.
module fifo_wr_arbiter
    import fifo_pack::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int GW        = $clog2(N_REQ),
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        drop_err
);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [CW-1:0]         burst_q, burst_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic                  ack_exp_q, ack_exp_d;
    logic                  drop_q, drop_d;

    logic                  space_ok_s;
    logic                  own_valid_s;
    logic [FIFO_WIDTH-1:0] own_data_s;
    logic                  xfer_s;
    logic [CW-1:0]         burst_inc_s;
    logic                  grant_end_s;
    logic [GW-1:0]         grant_inc_s;
    logic [GW-1:0]         pick_start_s;
    logic                  pick_found_s;
    logic [GW-1:0]         pick_idx_s;

    // The registered beat still in flight counts against almost-full.
    assign space_ok_s   = !fifo_full && !(wr_en_q && fifo_almostfull);
    assign own_valid_s  = req_valid[grant_q];
    assign xfer_s       = (state_q == ARB_GRANT) && space_ok_s && own_valid_s;
    assign burst_inc_s  = burst_q + CW'(1);
    assign grant_end_s  = (xfer_s && (burst_inc_s == CW'(MAX_BURST))) || !own_valid_s;
    assign grant_inc_s  = GW'(rr_wrap_inc(int'(grant_q), N_REQ));
    assign pick_start_s = (state_q == ARB_GRANT) ? grant_inc_s : rr_q;

    rr_pick #(
        .N  (N_REQ),
        .IW (GW)
    ) u_pick (
        .req   (req_valid),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Select the current owner's data slice.
    always_comb begin
        own_data_s = {FIFO_WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                own_data_s = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end else begin
                own_data_s = own_data_s;
            end
        end
    end

    // Ready goes only to the owner, and never while reset is applied.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        if (!rst && (state_q == ARB_GRANT) && space_ok_s) begin
            req_ready[grant_q] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Grant FSM: burst counting, rotation and zero-cycle hand-over.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_idx_s;
                    burst_d = {CW{1'b0}};
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (xfer_s) begin
                    burst_d = burst_inc_s;
                end else begin
                    burst_d = burst_q;
                end
                if (grant_end_s) begin
                    rr_d    = grant_inc_s;
                    burst_d = {CW{1'b0}};
                    if (pick_found_s) begin
                        state_d = ARB_GRANT;
                        grant_d = pick_idx_s;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = {GW{1'b0}};
                rr_d    = {GW{1'b0}};
                burst_d = {CW{1'b0}};
            end
        endcase
    end

    // Write-port register and acknowledge supervision.
    always_comb begin
        wr_en_d   = xfer_s;
        ack_exp_d = wr_en_q;
        drop_d    = drop_q || (ack_exp_q && !fifo_wr_ack) || fifo_overflow;
        if (xfer_s) begin
            data_d = own_data_s;
        end else begin
            data_d = data_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= {GW{1'b0}};
            rr_q      <= {GW{1'b0}};
            burst_q   <= {CW{1'b0}};
            wr_en_q   <= 1'b0;
            data_q    <= {FIFO_WIDTH{1'b0}};
            ack_exp_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            burst_q   <= burst_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            ack_exp_q <= ack_exp_d;
            drop_q    <= drop_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q == ARB_GRANT);
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues and a FIFO occupancy model
// drive the DUT, and a transaction-level arbitration model predicts every output.
module tb_fifo_wr_arbiter;
    import fifo_pack::*;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int W  = FIFO_WIDTH;
    localparam int D  = FIFO_DEPTH;
    localparam int GW = $clog2(N);

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_data_in;
    logic            fifo_full;
    logic            fifo_almostfull;
    logic            fifo_wr_ack;
    logic            fifo_overflow;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            drop_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .grant_id        (grant_id),
        .busy            (busy),
        .drop_err        (drop_err)
    );

    int errors;
    int checks;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment: producer beat queues, FIFO occupancy and logs.
    logic [W-1:0] pq [N][$];
    int           fifo_cnt;
    bit           kill_ack;
    bit           ovf_seen;
    bit           check_on;
    int           cyc;
    int           wr_cyc [$];
    logic [W-1:0] wr_dat [$];
    int           hs_own [$];
    int           hs_cyc [$];

    // Reference model: owner (-1 = nobody), beats in this grant, rotation pointer.
    int           m_owner;
    int           m_cnt;
    int           m_rr;
    bit           m_wr;
    bit           m_ack_exp;
    bit           m_drop;
    logic [W-1:0] m_data;

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_rr = 0;
        m_wr = 1'b0; m_ack_exp = 1'b0; m_drop = 1'b0; m_data = '0;
    endtask

    task automatic tick(input bit rst_in, input bit rd_in);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] pop;
        logic [W-1:0] beat;
        logic [W-1:0] dsel;
        bit space, xfer, wr_seen, ack_in, ovf_in, ok;
        int own, p;
        @(negedge clk);
        rst = rst_in;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pq[i].size() > 0);
            beat = (pq[i].size() > 0) ? pq[i][0] : '0;
            req_data[i*W +: W] = beat;
        end
        fifo_full       = (fifo_cnt >= D);
        fifo_almostfull = (fifo_cnt >= D - 1);
        #1;
        v     = req_valid;
        own   = (m_owner < 0) ? 0 : m_owner;
        space = !fifo_full && !(m_wr && fifo_almostfull);
        exp_rdy = '0;
        if (!rst_in && m_owner >= 0 && space) exp_rdy[own] = 1'b1;
        if (check_on) begin
            check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
            check_val("busy", 64'(busy), 64'(m_owner >= 0));
            if (m_owner >= 0) check_val("grant_id", 64'(grant_id), 64'(m_owner));
            check_val("fifo_wr_en", 64'(fifo_wr_en), 64'(m_wr));
            check_val("fifo_data_in", 64'(fifo_data_in), 64'(m_data));
            check_val("drop_err", 64'(drop_err), 64'(m_drop));
        end
        xfer    = (m_owner >= 0) && exp_rdy[own] && v[own];
        dsel    = req_data[own*W +: W];
        wr_seen = fifo_wr_en;
        ack_in  = fifo_wr_ack;
        ovf_in  = fifo_overflow;
        pop     = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                hs_own.push_back(i);
                hs_cyc.push_back(cyc);
            end
        end
        if (wr_seen) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_data_in);
        end
        @(posedge clk);
        #1;
        if (rst_in) begin
            model_reset();
        end else begin
            m_drop    = m_drop || (m_ack_exp && !ack_in) || ovf_in;
            m_ack_exp = m_wr;
            m_wr      = xfer;
            if (xfer) m_data = dsel;
            if (m_owner < 0) begin
                p = pick(v, m_rr);
                if (p >= 0) begin
                    m_owner = p;
                    m_cnt   = 0;
                end
            end else begin
                if (xfer) m_cnt++;
                if ((xfer && m_cnt == MB) || !v[m_owner]) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = pick(v, m_rr);
                    m_cnt   = 0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pop[i]) void'(pq[i].pop_front());
        end
        ok = wr_seen && (fifo_cnt < D);
        if (rd_in && fifo_cnt > 0) fifo_cnt--;
        if (ok) fifo_cnt++;
        fifo_wr_ack   = ok && !kill_ack;
        if (ok && kill_ack) kill_ack = 1'b0;
        fifo_overflow = wr_seen && !ok;
        if (fifo_overflow) ovf_seen = 1'b1;
        cyc++;
    endtask

    task automatic restart();
        for (int i = 0; i < N; i++) pq[i].delete();
        kill_ack = 1'b0;
        tick(1'b1, 1'b0);
        fifo_cnt = 0;
        wr_cyc.delete(); wr_dat.delete(); hs_own.delete(); hs_cyc.delete();
    endtask

    initial begin
        int  c0;
        bit  found;
        errors = 0; checks = 0; cyc = 0; fifo_cnt = 0;
        kill_ack = 1'b0; ovf_seen = 1'b0; check_on = 1'b0;
        rst = 1'b1; req_valid = '0; req_data = '0;
        fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
        model_reset();

        // Reset held two cycles with every producer valid, then first grant to 0.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) pq[i].push_back(W'(i * 256 + k));
        tick(1'b1, 1'b0);
        check_on = 1'b1;
        tick(1'b1, 1'b0);
        check_val("rst_grant_id", 64'(grant_id), 64'd0);
        check_val("rst_ready", 64'(req_ready), 64'd0);
        tick(1'b0, 1'b1);
        check_val("first_busy", 64'(busy), 64'd1);
        check_val("first_grant", 64'(grant_id), 64'd0);

        // Producer 0 alone: three beats written on cycles 2,3,4.
        restart();
        pq[0].push_back(W'(32'h00A1)); pq[0].push_back(W'(32'h00A2)); pq[0].push_back(W'(32'h00A3));
        c0 = cyc;
        repeat (8) tick(1'b0, 1'b1);
        check_val("b_writes", 64'(wr_cyc.size()), 64'd3);
        for (int k = 0; k < 3 && k < wr_cyc.size(); k++) begin
            check_val("b_data", 64'(wr_dat[k]), 64'(32'h00A1 + k));
            check_val("b_cycle", 64'(wr_cyc[k] - c0), 64'(2 + k));
        end
        check_val("b_drop", 64'(drop_err), 64'd0);

        // All four producers saturated, FIFO drained: 4-beat bursts 0,1,2,3,0.
        restart();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 24; k++) pq[i].push_back(W'(i * 256 + k));
        c0 = cyc;
        repeat (22) tick(1'b0, 1'b1);
        check_val("c_count", 64'(hs_own.size() >= 20), 64'd1);
        for (int k = 0; k < 20 && k < hs_own.size(); k++) begin
            check_val("c_owner", 64'(hs_own[k]), 64'((k / MB) % N));
            check_val("c_gap", 64'(hs_cyc[k] - c0), 64'(k + 1));
        end

        // Producer 2 streams, no reads: exactly D writes, then one read admits one more.
        restart();
        ovf_seen = 1'b0;
        for (int k = 0; k < 20; k++) pq[2].push_back(W'(32'h2000 + k));
        repeat (24) tick(1'b0, 1'b0);
        check_val("d_writes", 64'(wr_cyc.size()), 64'(D));
        check_val("d_ready", 64'(req_ready), 64'd0);
        tick(1'b0, 1'b1);
        repeat (8) tick(1'b0, 1'b0);
        check_val("d_one_more", 64'(wr_cyc.size()), 64'(D + 1));
        check_val("d_overflow", 64'(ovf_seen), 64'd0);

        // Missing acknowledge sets a sticky error, cleared only by reset.
        restart();
        pq[0].push_back(W'(32'h00E1));
        kill_ack = 1'b1;
        repeat (6) tick(1'b0, 1'b1);
        check_val("e_drop", 64'(drop_err), 64'd1);
        repeat (3) tick(1'b0, 1'b1);
        check_val("e_sticky", 64'(drop_err), 64'd1);
        tick(1'b1, 1'b0);
        check_val("e_cleared", 64'(drop_err), 64'd0);

        // Reset on producer 1's second beat; next grant restarts from index 0.
        restart();
        pq[2].push_back(W'(32'h0201)); pq[2].push_back(W'(32'h0202));
        repeat (6) tick(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) pq[1].push_back(W'(32'h0100 + k));
        hs_own.delete();
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick(1'b0, 1'b1);
            if (hs_own.size() > 0) found = 1'b1;
        end
        check_val("f_first_beat", 64'(found), 64'd1);
        for (int k = 0; k < 6; k++) pq[3].push_back(W'(32'h0300 + k));
        tick(1'b1, 1'b1);
        check_val("f_no_wr", 64'(fifo_wr_en), 64'd0);
        check_val("f_idle", 64'(busy), 64'd0);
        tick(1'b0, 1'b1);
        check_val("f_busy", 64'(busy), 64'd1);
        check_val("f_grant", 64'(grant_id), 64'd1);

        // Randomized traffic, drain rate and occasional lost acks / resets.
        restart();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && pq[i].size() < 6) pq[i].push_back(W'($urandom));
            if ($urandom_range(0, 149) == 0) kill_ack = 1'b1;
            if (((t / 500) % 2) == 0)
                tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
            else
                tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
